// File: rtl/gp_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : gp_cmd_sequencer_if
//  Purpose  : Command handshake bundle between a requester and the
//             graphics-processor command sequencer.
//  Signals  : cmd_valid  - requester presents a command
//             cmd_ready  - sequencer FIFO can accept (not full)
//             cmd_op     - 0 = fill, 1 = draw
//             cmd_tl     - top-left corner, x in [25:16], y in [8:0]
//             cmd_br     - bottom-right corner, same packing
//             cmd_arg    - fill colour / ROM base in [11:0]
//  Modports : master = requester side, slave = sequencer side
//  Revision : 1.0  initial release
// ============================================================================
interface gp_cmd_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [31:0] cmd_tl;
   logic [31:0] cmd_br;
   logic [31:0] cmd_arg;

   modport master (
      output cmd_valid, cmd_op, cmd_tl, cmd_br, cmd_arg,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_tl, cmd_br, cmd_arg,
      output cmd_ready
   );
endinterface
`default_nettype wire

// File: rtl/gp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : gp_cmd_sequencer
//  Purpose  : Queues fill/draw commands in a small FIFO and replays each one
//             to the graphics processor as a register-write sequence:
//             TL, BR, ARG, CTRL(start), wait for finish, CTRL(stop).
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             cmd (slave)     - command handshake bundle
//             gp_ctrl/tl/br/arg      - register data buses to the processor
//             gp_*_we                - one-cycle write strobes
//             gp_finish       - processor done flag (looked at only in WAIT)
//             busy            - FSM active or commands queued
//             pending         - FIFO occupancy
//             timeout_err     - sticky watchdog flag
//  Options  : GP_SEQ_TIMEOUT_EN - builds a WAIT watchdog of TIMEOUT_CYCLES;
//             when undefined, WAIT lasts until gp_finish and timeout_err = 0.
//  Revision : 1.0  initial release
// ============================================================================
module gp_cmd_sequencer #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                     clk,
   input  logic                     rst,
   gp_cmd_sequencer_if.slave        cmd,
   output logic [31:0]              gp_ctrl,
   output logic [31:0]              gp_tl,
   output logic [31:0]              gp_br,
   output logic [31:0]              gp_arg,
   output logic                     gp_ctrl_we,
   output logic                     gp_tl_we,
   output logic                     gp_br_we,
   output logic                     gp_arg_we,
   input  logic                     gp_finish,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     timeout_err
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   // {op, tl.x[9:0], tl.y[8:0], br.x[9:0], br.y[8:0], arg[11:0]}
   localparam int c_ENT_W = 51;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LD_TL  = 3'd1,
      S_LD_BR  = 3'd2,
      S_LD_ARG = 3'd3,
      S_START  = 3'd4,
      S_WAIT   = 3'd5,
      S_STOP   = 3'd6
   } state_t;

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
         $error("gp_cmd_sequencer: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
      end
   endgenerate

   state_t               r_state;
   logic                 r_op;
   logic [c_ENT_W-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;

   logic [c_ENT_W-1:0]   w_wr_entry;
   logic [c_ENT_W-1:0]   w_head;
   logic                 w_full;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_unused_bits;

   assign w_full        = (pending == c_CNT_W'(DEPTH));
   assign cmd.cmd_ready = ~w_full;
   assign w_push        = cmd.cmd_valid & ~w_full;
   // Pop only from IDLE, and only when the registered count says non-empty,
   // so an entry pushed on this same edge is never popped before it lands.
   assign w_pop         = (r_state == S_IDLE) && (pending != '0);

   assign w_wr_entry = {cmd.cmd_op,
                        cmd.cmd_tl[25:16], cmd.cmd_tl[8:0],
                        cmd.cmd_br[25:16], cmd.cmd_br[8:0],
                        cmd.cmd_arg[11:0]};
   assign w_head     = r_mem[r_rd_ptr];

   assign w_unused_bits = ^{cmd.cmd_tl[31:26], cmd.cmd_tl[15:9],
                            cmd.cmd_br[31:26], cmd.cmd_br[15:9],
                            cmd.cmd_arg[31:12]};

   assign busy = (r_state != S_IDLE) || (pending != '0);

   // ------------------------------------------------------------------------
   // Command FIFO. Storage is not reset; contents are meaningless once the
   // pointers and count are cleared.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_wr_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         pending  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   pending <= pending + 1'b1;
            2'b01:   pending <= pending - 1'b1;
            default: pending <= pending;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Optional WAIT watchdog
   // ------------------------------------------------------------------------
`ifdef GP_SEQ_TIMEOUT_EN
   localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

   logic [c_TO_W-1:0] r_to_cnt;
   logic              r_timeout_err;

   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Sequencer FSM. Strobes are set on the edge that enters the state they
   // belong to, so each strobe is high for exactly the cycle spent there.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_op       <= 1'b0;
         gp_ctrl    <= '0;
         gp_tl      <= '0;
         gp_br      <= '0;
         gp_arg     <= '0;
         gp_ctrl_we <= 1'b0;
         gp_tl_we   <= 1'b0;
         gp_br_we   <= 1'b0;
         gp_arg_we  <= 1'b0;
`ifdef GP_SEQ_TIMEOUT_EN
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         gp_ctrl_we <= 1'b0;
         gp_tl_we   <= 1'b0;
         gp_br_we   <= 1'b0;
         gp_arg_we  <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_op     <= w_head[50];
                  gp_tl    <= {6'd0, w_head[49:40], 7'd0, w_head[39:31]};
                  gp_br    <= {6'd0, w_head[30:21], 7'd0, w_head[20:12]};
                  gp_arg   <= {20'd0, w_head[11:0]};
                  gp_tl_we <= 1'b1;
                  r_state  <= S_LD_TL;
               end
            end
            S_LD_TL: begin
               gp_br_we <= 1'b1;
               r_state  <= S_LD_BR;
            end
            S_LD_BR: begin
               gp_arg_we <= 1'b1;
               r_state   <= S_LD_ARG;
            end
            S_LD_ARG: begin
               // ctrl = {en, op}; en kicks the processor off
               gp_ctrl    <= {30'd0, 1'b1, r_op};
               gp_ctrl_we <= 1'b1;
               r_state    <= S_START;
            end
            S_START: begin
`ifdef GP_SEQ_TIMEOUT_EN
               r_to_cnt <= '0;
`endif
               r_state  <= S_WAIT;
            end
            S_WAIT: begin
               if (gp_finish) begin
                  gp_ctrl    <= '0;
                  gp_ctrl_we <= 1'b1;
                  r_state    <= S_STOP;
               end
`ifdef GP_SEQ_TIMEOUT_EN
               else if (r_to_cnt == c_TO_LAST) begin
                  gp_ctrl       <= '0;
                  gp_ctrl_we    <= 1'b1;
                  r_timeout_err <= 1'b1;
                  r_state       <= S_STOP;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
`endif
            end
            S_STOP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gp_cmd_sequencer
//  Purpose  : Randomized self-checking bench for gp_cmd_sequencer. A
//             timeline model (command queue plus start/finish edge numbers)
//             predicts strobes, buses, pending, ready, busy and timeout_err.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gp_cmd_sequencer;

   localparam int DEPTH  = 4;
   localparam int TO_CYC = 16;

   typedef struct {
      bit          op;
      logic [31:0] tl;
      logic [31:0] br;
      logic [31:0] arg;
   } cmd_t;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    gp_finish = 1'b0;
   logic [31:0]             gp_ctrl, gp_tl, gp_br, gp_arg;
   logic                    gp_ctrl_we, gp_tl_we, gp_br_we, gp_arg_we;
   logic                    busy;
   logic [$clog2(DEPTH):0]  pending;
   logic                    timeout_err;

   gp_cmd_sequencer_if cmd_if ();

   gp_cmd_sequencer #(
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd         (cmd_if),
      .gp_ctrl     (gp_ctrl),
      .gp_tl       (gp_tl),
      .gp_br       (gp_br),
      .gp_arg      (gp_arg),
      .gp_ctrl_we  (gp_ctrl_we),
      .gp_tl_we    (gp_tl_we),
      .gp_br_we    (gp_br_we),
      .gp_arg_we   (gp_arg_we),
      .gp_finish   (gp_finish),
      .busy        (busy),
      .pending     (pending),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // ---------------- model state ----------------
   // e counts rising edges; s = edge that popped the current command,
   // f = edge at which its WAIT ends (finish sampled or watchdog expiry).
   int   e = 0;
   int   s = -100;
   int   f = -90;
   int   idle_avail = 0;
   cmd_t q[$];
   cmd_t cur;
   bit   to_cur = 1'b0;
   bit   m_err = 1'b0;
   bit   want_timeout = 1'b0;
   int   wmin = 1;
   int   wmax = 3;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, e);
   endtask

   // Advance the model across edge e given what was presented before it.
   task automatic model_edge(input bit v, input cmd_t c);
      bit full;
      full = (q.size() == DEPTH);
      if (e >= idle_avail && q.size() != 0) begin
         cur = q.pop_front();
         s   = e;
         if (want_timeout) begin
            to_cur       = 1'b1;
            f            = s + 4 + TO_CYC;
            want_timeout = 1'b0;
         end else begin
            to_cur = 1'b0;
            f      = s + 4 + int'($urandom_range(wmax, wmin));
         end
         idle_avail = f + 2;
      end
      if (v && !full) q.push_back(c);
      if (to_cur && e == f) m_err = 1'b1;
   endtask

   // Finish level for the next edge: low throughout WAIT until the chosen
   // edge, random anywhere else (it must be ignored there).
   function automatic bit finish_next();
      int n;
      n = e + 1;
      if (n >= s + 5 && n < f) return 1'b0;
      if (n == f) return !to_cur;
      return ($urandom_range(0, 3) == 0);
   endfunction

   task automatic check_outputs();
      bit         in_cmd;
      logic [3:0] exp_we;
      in_cmd = (e >= s && e <= f);
      exp_we = {(e == s + 3) || (e == f), e == s, e == s + 1, e == s + 2};
      check_eq("strobes{ctrl,tl,br,arg}", {gp_ctrl_we, gp_tl_we, gp_br_we, gp_arg_we}, exp_we);
      if (in_cmd) begin
         check_eq("gp_tl",  gp_tl,  cur.tl);
         check_eq("gp_br",  gp_br,  cur.br);
         check_eq("gp_arg", gp_arg, cur.arg);
      end
      if (exp_we[3])
         check_eq("gp_ctrl", gp_ctrl, (e == f) ? 32'd0 : {30'd0, 1'b1, cur.op});
      check_eq("pending",     pending, q.size());
      check_eq("cmd_ready",   cmd_if.cmd_ready, q.size() != DEPTH);
      check_eq("busy",        busy, in_cmd || q.size() != 0);
      check_eq("timeout_err", timeout_err, m_err);
   endtask

   // One clock: called just after a falling edge.
   task automatic tick(input bit v);
      cmd_t c;
      c.op  = 1'($urandom_range(0, 1));
      c.tl  = $urandom;
      c.br  = $urandom;
      c.arg = $urandom;
      cmd_if.cmd_valid = v;
      cmd_if.cmd_op    = c.op;
      cmd_if.cmd_tl    = c.tl;
      cmd_if.cmd_br    = c.br;
      cmd_if.cmd_arg   = c.arg;
      gp_finish        = finish_next();
      @(posedge clk);
      @(negedge clk);
      e++;
      c.tl  = c.tl  & 32'h03FF_01FF;
      c.br  = c.br  & 32'h03FF_01FF;
      c.arg = c.arg & 32'h0000_0FFF;
      model_edge(v, c);
      check_outputs();
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((q.size() != 0 || e <= f) && guard < 400) begin
         tick(1'b0);
         guard++;
      end
   endtask

   initial begin
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 1'b0;
      cmd_if.cmd_tl    = '0;
      cmd_if.cmd_br    = '0;
      cmd_if.cmd_arg   = '0;

      // reset state
      repeat (3) @(negedge clk);
      check_eq("rst_strobes", {gp_ctrl_we, gp_tl_we, gp_br_we, gp_arg_we}, 4'd0);
      check_eq("rst_ctrl", gp_ctrl, 0);
      check_eq("rst_tl",   gp_tl,   0);
      check_eq("rst_br",   gp_br,   0);
      check_eq("rst_arg",  gp_arg,  0);
      check_eq("rst_pending", pending, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_timeout_err", timeout_err, 0);
      rst = 1'b0;
      check_eq("rst_ready", cmd_if.cmd_ready, 1);

      // short waits, sparse pushes
      wmin = 1; wmax = 3;
      repeat (300) tick($urandom_range(0, 99) < 30);

      // long waits, dense pushes: FIFO fills and refuses extra commands
      wmin = 10; wmax = 15;
      repeat (300) tick($urandom_range(0, 99) < 80);

`ifdef GP_SEQ_TIMEOUT_EN
      // watchdog expiry, then a queued command still runs
      drain();
      want_timeout = 1'b1;
      wmin = 2; wmax = 2;
      tick(1'b1);
      tick(1'b1);
      repeat (40) tick(1'b0);
`endif

      // reset while in WAIT with two commands queued
      drain();
      wmin = 15; wmax = 15;
      tick(1'b1);
      tick(1'b1);
      tick(1'b1);
      repeat (5) tick(1'b0);
      check_eq("pre_rst_pending", pending, 2);
      cmd_if.cmd_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("arst_strobes", {gp_ctrl_we, gp_tl_we, gp_br_we, gp_arg_we}, 4'd0);
      check_eq("arst_ctrl", gp_ctrl, 0);
      check_eq("arst_tl",   gp_tl,   0);
      check_eq("arst_br",   gp_br,   0);
      check_eq("arst_arg",  gp_arg,  0);
      check_eq("arst_pending", pending, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_timeout_err", timeout_err, 0);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      s = e - 100;
      f = e - 90;
      idle_avail = 0;
      to_cur = 1'b0;
      m_err = 1'b0;
      repeat (12) tick(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gp_cmd_sequencer.md
GP_CMD_SEQUENCER -- requirements
Module: gp_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO entries; power of two, at least 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 1048576: watchdog limit in WAIT cycles; used only with GP_SEQ_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  requester presents a command.
REQ-006 cmd_ready  output  1  FIFO can accept a command (not full).
REQ-007 cmd_op  input  1  0 = fill, 1 = draw.
REQ-008 cmd_tl  input  32  top-left corner: x in [25:16], y in [8:0].
REQ-009 cmd_br  input  32  bottom-right corner, same packing as cmd_tl.
REQ-010 cmd_arg  input  32  fill colour or ROM base in [11:0]; upper bits ignored.
REQ-011 gp_ctrl, gp_tl, gp_br, gp_arg  output  32 each  data buses to the graphics processor register inputs.
REQ-012 gp_ctrl_we, gp_tl_we, gp_br_we, gp_arg_we  output  1 each  write strobes to the graphics processor.
REQ-013 gp_finish  input  1  graphics processor finish flag.
REQ-014 busy  output  1  high whenever the state is not IDLE or the FIFO is non-empty.
REQ-015 pending  output  $clog2(DEPTH)+1  number of FIFO entries.
REQ-016 timeout_err  output  1  sticky watchdog flag.

Function
REQ-017 Push occurs when cmd_valid && cmd_ready; cmd_ready = (pending != DEPTH).
REQ-018 Each FIFO entry stores {op, tl[25:16], tl[8:0], br[25:16], br[8:0], arg[11:0]}; read and write pointers wrap modulo DEPTH.
REQ-019 A push and a pop in the same cycle leave pending unchanged; pop from an empty FIFO never occurs.
REQ-020 FSM states: IDLE, LD_TL, LD_BR, LD_ARG, START, WAIT, STOP.
REQ-021 IDLE with pending > 0: pop the head into the current-command registers and go to LD_TL; otherwise stay in IDLE.
REQ-022 LD_TL asserts gp_tl_we for exactly 1 cycle, then goes to LD_BR; LD_BR asserts gp_br_we, then goes to LD_ARG; LD_ARG asserts gp_arg_we, then goes to START.
REQ-023 START asserts gp_ctrl_we with gp_ctrl = {30'b0, 1'b1, op} for 1 cycle, then goes to WAIT.
REQ-024 WAIT has no strobes; gp_finish sampled high goes to STOP.
REQ-025 STOP asserts gp_ctrl_we with gp_ctrl = 0 (en cleared, graphics processor returns to its init state), then goes to IDLE.
REQ-026 Strobes are registered and decoded from state, at most one strobe per cycle. Data buses zero-extend the stored fields to the packing in REQ-008..010 and stay stable from LD_TL through STOP.
REQ-027 Latency: a command pushed into an empty FIFO while IDLE at edge N produces gp_tl_we high in the cycle after edge N+1 and gp_ctrl_we (start) 3 cycles after that.
REQ-028 Minimum command period is 6 cycles plus the WAIT duration; back-to-back commands pass through IDLE for exactly 1 cycle.
REQ-029 gp_finish is ignored in every state except WAIT.
REQ-030 Pushes are accepted in every state, including while the FSM is mid-command.

Reset
REQ-031 On rst high, asynchronously: state = IDLE, pointers and pending = 0, all strobes 0, all gp_* buses 0, timeout_err = 0, cmd_ready = 1 after release.
REQ-032 Reset mid-command abandons the command without a STOP write; the FIFO contents are discarded.

Configuration
REQ-033 With GP_SEQ_TIMEOUT_EN defined, a counter clears on WAIT entry and increments each WAIT cycle. Reaching TIMEOUT_CYCLES without gp_finish goes to STOP and sets timeout_err, which holds until rst.
REQ-034 Without GP_SEQ_TIMEOUT_EN, no counter is built, timeout_err is tied to 0, and WAIT persists until gp_finish.

Verification
REQ-035 Single fill: op=0, tl=0x000A0005, br=0x000B0006, arg=0xF00 -> strobes in order tl/br/arg/ctrl on 4 consecutive cycles, gp_ctrl=0x3? no; gp_ctrl=0x2 at start; finish after 10 cycles -> gp_ctrl=0 write, then busy=0.
REQ-036 Fill FIFO: 4 pushes while WAIT stalls -> pending=4, cmd_ready=0, a 5th cmd_valid is not accepted. Finish then arrives -> pending=3 after next IDLE pop, and commands execute in push order.
REQ-037 Simultaneous push and pop at pending=2 -> pending stays 2, and the popped entry is the oldest.
REQ-038 Draw: op=1, arg=0x123 -> gp_ctrl=0x3, gp_arg=0x00000123. gp_finish pulsed during LD_BR -> ignored, and the FSM still reaches WAIT.
REQ-039 rst asserted in WAIT with pending=2 -> all outputs 0 immediately, pending=0, and no further strobes until a new push.
REQ-040 GP_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=16 and gp_finish held 0 -> STOP after 16 WAIT cycles, timeout_err=1, and the next queued command still executes.
